// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit ripple adder split into NSEG = WIDTH/SEG_W segments.
// One segment is added per pipeline stage. The segment carry is registered
// into the next stage.
// A per-stage valid/ready handshake gives full throughput with bubble-
// collapsing backpressure.
// Optional feature: define ADDER_PIPE_OVF_EN to build the signed-overflow
// flag. Without it, ovf is tied low.
module adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din_one,
  input  logic [WIDTH-1:0] din_two,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int LAST = NSEG - 1;

  // Stage k holds valid, the carry out of segment k, sum segments 0..k in
  // sum_q[k], and operands in a_q/b_q. Only segments k+1.. of the operands
  // are consumed downstream.
  logic [NSEG-1:0]  v_q, v_d;
  logic [NSEG-1:0]  carry_q, carry_d;
  logic [WIDTH-1:0] sum_q [NSEG];
  logic [WIDTH-1:0] sum_d [NSEG];
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] a_d   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] b_d   [NSEG];

  // What each stage would load: the inputs for stage 0, otherwise the
  // contents of the previous stage.
  logic [NSEG-1:0]  src_v;
  logic [NSEG-1:0]  src_c;
  logic [WIDTH-1:0] src_a   [NSEG];
  logic [WIDTH-1:0] src_b   [NSEG];
  logic [WIDTH-1:0] src_sum [NSEG];
  logic [SEG_W:0]   seg_res [NSEG];
  logic [WIDTH-1:0] merged  [NSEG];

  logic [NSEG-1:0]  adv;
  logic [NSEG-1:0]  load;

  // Advance chain: a stage may move when it is empty or its successor moves.
  // The chain depends only on valid bits and out_ready, never on in_valid.
  always_comb begin
    adv       = '0;
    adv[LAST] = !v_q[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end
  end

  assign in_ready = adv[0];

  // Per-stage segment add and next-state selection (load on advance, else hold).
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves a value unassigned and no latch is inferred.
    src_v      = '0;
    src_c      = '0;
    v_d        = v_q;
    carry_d    = carry_q;
    load       = '0;

    src_v[0]   = in_valid;
    src_c[0]   = cin;
    src_a[0]   = din_one;
    src_b[0]   = din_two;
    src_sum[0] = '0;
    for (int k = 1; k < NSEG; k++) begin
      src_v[k]   = v_q[k-1];
      src_c[k]   = carry_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_sum[k] = sum_q[k-1];
    end

    for (int k = 0; k < NSEG; k++) begin
      seg_res[k] = {1'b0, src_a[k][k*SEG_W +: SEG_W]}
                 + {1'b0, src_b[k][k*SEG_W +: SEG_W]}
                 + {{SEG_W{1'b0}}, src_c[k]};
      merged[k]  = src_sum[k];
      merged[k][k*SEG_W +: SEG_W] = seg_res[k][SEG_W-1:0];

      // Data is captured only for a real transfer. A bubble moving into the
      // last stage must not disturb the last result shown on the outputs.
      load[k]  = adv[k] && src_v[k];
      sum_d[k] = sum_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      if (adv[k]) begin
        v_d[k] = src_v[k];
      end
      if (load[k]) begin
        carry_d[k] = seg_res[k][SEG_W];
        sum_d[k]   = merged[k];
        a_d[k]     = src_a[k];
        b_d[k]     = src_b[k];
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      carry_q <= '0;
      // NOTE: the data registers are reset too, not only the valid bits.
      // The last stage drives sum/cout directly and must come up as zero.
      // One reset process for all stage data keeps the stages uniform.
      for (int k = 0; k < NSEG; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments, so every stage samples its
      // predecessor's pre-edge value and data shifts exactly one stage per edge.
      v_q     <= v_d;
      carry_q <= carry_d;
      for (int k = 0; k < NSEG; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = carry_q[LAST];

`ifdef ADDER_PIPE_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: the operands share a sign and the sum's sign differs.
  // The operand MSBs reach the last stage inside the forwarded top segment.
  always_comb begin
    ovf_d = ovf_q;
    if (load[LAST]) begin
      ovf_d = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
              (merged[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    end
  end

  // Overflow register, captured and held together with sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Testbench for adder_pipe. It drives a 32-bit/8-bit-segment instance
// (4 stages) and a 16-bit single-segment instance.
`timescale 1ns/1ps
module tb_adder_pipe;

`ifdef ADDER_PIPE_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam int NSEG = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [31:0] din_one, din_two, sum;

  // 16-bit single-stage instance
  logic        in_valid_s, in_ready_s, cin_s, out_valid_s, out_ready_s, cout_s, ovf_s;
  logic [15:0] din_one_s, din_two_s, sum_s;

  adder_pipe #(.WIDTH(32), .SEG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .din_one(din_one), .din_two(din_two), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  adder_pipe #(.WIDTH(16), .SEG_W(16)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s), .in_ready(in_ready_s),
    .din_one(din_one_s), .din_two(din_two_s), .cin(cin_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .sum(sum_s), .cout(cout_s), .ovf(ovf_s)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] s;
    logic        co;
    logic        ov;   // expected when the overflow feature is built
  } vec_t;

  vec_t vecs [10];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Scoreboard state: expected {ovf, cout, sum} in acceptance order.
  logic [33:0] exp_q [$];
  int          accepts, received;
  int          first_in_cyc, first_out_cyc, last_out_cyc;
  logic        hold_pending;
  logic [31:0] held_sum;
  logic        held_cout, held_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] s;
    logic        o;
    s = {1'b0, a} + {1'b0, b} + {32'd0, c};
    o = OVF_EN && (a[31] == b[31]) && (s[31] != a[31]);
    return {o, s};
  endfunction

  // One clock of the 32-bit instance with scoreboard bookkeeping. Inputs are
  // already set. Transfers are evaluated just before the edge.
  task automatic cycle();
    if (hold_pending) begin
      check("stall_valid", out_valid, 1);
      check("stall_sum", sum, held_sum);
      check("stall_cout", cout, held_cout);
      check("stall_ovf", ovf, held_ovf);
    end
    if (out_valid && out_ready) begin
      check("out_has_expectation", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check("stream_result", {ovf, cout, sum}, exp_q.pop_front());
      end
      received++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end
    hold_pending = out_valid && !out_ready;
    held_sum     = sum;
    held_cout    = cout;
    held_ovf     = ovf;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(din_one, din_two, cin));
      if (accepts == 0) first_in_cyc = cyc;
      accepts++;
    end
    step();
  endtask

  task automatic reset_sb();
    exp_q.delete();
    accepts       = 0;
    received      = 0;
    first_in_cyc  = -1;
    first_out_cyc = -1;
    last_out_cyc  = -1;
    hold_pending  = 1'b0;
  endtask

  // Single transaction through the 4-stage instance, with a latency measurement.
  task automatic run_single(input string name, input vec_t v);
    int lat;
    out_ready = 1'b1;
    check({name, "_in_ready"}, in_ready, 1);
    din_one  = v.a;
    din_two  = v.b;
    cin      = v.c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({name, "_latency"}, lat, NSEG);
    check({name, "_sum"}, sum, v.s);
    check({name, "_cout"}, cout, v.co);
    check({name, "_ovf"}, ovf, OVF_EN ? v.ov : 1'b0);
  endtask

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[3] = '{32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0};
    vecs[4] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b1, 32'h0000_0101, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[9] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};

    rst_n       = 1'b0;
    in_valid    = 1'b0;  din_one   = '0; din_two   = '0; cin   = 1'b0; out_ready   = 1'b0;
    in_valid_s  = 1'b0;  din_one_s = '0; din_two_s = '0; cin_s = 1'b0; out_ready_s = 1'b1;
    reset_sb();

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid_s", out_valid_s, 0);
    #21;
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // Directed table, one transaction at a time
    for (int i = 0; i < 10; i++) begin
      run_single($sformatf("vec%0d", i), vecs[i]);
    end
    step();

    // Streaming: 100 random pairs back to back
    out_ready = 1'b1;
    reset_sb();
    for (int i = 0; i < 100; i++) begin
      din_one  = $urandom;
      din_two  = $urandom;
      cin      = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      check("stream_in_ready", in_ready, 1);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    check("stream_drained", exp_q.size(), 0);
    check("stream_count", received, 100);
    check("stream_first_latency", first_out_cyc - first_in_cyc, NSEG);
    check("stream_contiguous", last_out_cyc - first_out_cyc, 99);

    // Backpressure: 10 stalled cycles while offering operands
    reset_sb();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din_one  = 32'h10 + 32'h100 * 32'(accepts);
      din_two  = 32'h20 + 32'(accepts);
      cin      = 1'b0;
      in_valid = 1'b1;
      cycle();
    end
    check("bp_accepts", accepts, NSEG);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_held_sum", sum, 32'h30);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", in_ready, 1);
    for (int i = 0; i < 40 && accepts < 8; i++) begin
      din_one  = 32'h10 + 32'h100 * 32'(accepts);
      din_two  = 32'h20 + 32'(accepts);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    check("bp_accepts_total", accepts, 8);
    check("bp_received", received, 8);
    check("bp_drained", exp_q.size(), 0);

    // Reset with three results in flight
    reset_sb();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_one  = 32'hA000_0000 + 32'(i);
      din_two  = 32'h0000_1111;
      cin      = 1'b1;
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    check("pre_rst_out_valid", out_valid, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    step();
    step();
    #2;
    rst_n = 1'b1;
    step();
    check("post_mid_rst_in_ready", in_ready, 1);
    run_single("after_rst", '{32'h0000_1234, 32'h0000_4321, 1'b0, 32'h0000_5555, 1'b0, 1'b0});
    step();

    // Single-stage instance: one-cycle latency, stall and overflow
    out_ready_s = 1'b1;
    din_one_s   = 16'h1234; din_two_s = 16'h0FFF; cin_s = 1'b1; in_valid_s = 1'b1;
    step();
    in_valid_s  = 1'b0;
    check("s1_out_valid", out_valid_s, 1);
    check("s1_sum", sum_s, 16'h2234);
    check("s1_cout", cout_s, 0);
    check("s1_ovf", ovf_s, 0);
    out_ready_s = 1'b0;
    din_one_s   = 16'h7FFF; din_two_s = 16'h0001; cin_s = 1'b0; in_valid_s = 1'b1;
    #1;
    check("s1_full_in_ready", in_ready_s, 0);
    step();
    check("s1_hold_sum", sum_s, 16'h2234);
    out_ready_s = 1'b1;
    #1;
    check("s1_in_ready_comb", in_ready_s, 1);
    step();
    check("s1_ovf_sum", sum_s, 16'h8000);
    check("s1_ovf_flag", ovf_s, OVF_EN);
    din_one_s   = 16'hFFFF; din_two_s = 16'h0001; cin_s = 1'b0;
    step();
    in_valid_s  = 1'b0;
    check("s1_wrap_sum", sum_s, 16'h0000);
    check("s1_wrap_cout", cout_s, 1);
    check("s1_wrap_ovf", ovf_s, 0);
    step();
    check("s1_empty", out_valid_s, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
